// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider: FSM states, legal
// width range and the magnitude / conditional-negate helpers.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int W_MIN = 2;
  localparam int W_MAX = 32;

  function automatic logic w_in_range(input int w);
    return (w >= W_MIN) && (w <= W_MAX);
  endfunction

  // Operands arrive sign- or zero-extended to W_MAX; callers truncate back.
  function automatic logic [W_MAX-1:0] abs_w(input logic [W_MAX-1:0] x,
                                             input logic signed_mode);
    return (signed_mode && x[W_MAX-1]) ? -x : x;
  endfunction

  function automatic logic [W_MAX-1:0] neg_w(input logic [W_MAX-1:0] x,
                                             input logic en);
    return en ? -x : x;
  endfunction

endpackage

// File: rtl/seq_div_core.sv
// Unsigned restoring division engine: one quotient bit per cycle after load,
// step_done marks the final iteration with q_raw/r_raw showing its result.
module seq_div_core
  import div_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] dividend_mag,
  input  logic [W-1:0] divisor_mag,
  output logic         step_done,
  output logic [W-1:0] q_raw,
  output logic [W-1:0] r_raw
);

  localparam int CW = $clog2(W + 1);

  logic [W:0]    r_q, r_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  d_q, d_d;
  logic [CW-1:0] count_q, count_d;
  logic          active_q, active_d;

  logic [2*W:0]  ra_sh;
  logic [W:0]    r_sh;
  logic [W-1:0]  a_sh;
  logic [W:0]    trial;

  always_comb begin
    ra_sh     = {r_q, a_q} << 1;
    r_sh      = ra_sh[2*W:W];
    a_sh      = ra_sh[W-1:0];
    trial     = r_sh - {1'b0, d_q};

    r_d       = r_q;
    a_d       = a_q;
    d_d       = d_q;
    count_d   = count_q;
    active_d  = active_q;
    step_done = 1'b0;

    if (load) begin
      r_d      = '0;
      a_d      = dividend_mag;
      d_d      = divisor_mag;
      count_d  = CW'(W);
      active_d = 1'b1;
    end else if (active_q) begin
      // A clear borrow bit means the divisor fits: keep the difference.
      if (!trial[W]) begin
        r_d = trial;
        a_d = {a_sh[W-1:1], 1'b1};
      end else begin
        r_d = r_sh;
        a_d = a_sh;
      end
      count_d = count_q - 1'b1;
      if (count_q == CW'(1)) begin
        step_done = 1'b1;
        active_d  = 1'b0;
      end
    end
  end

  assign q_raw = a_d;
  assign r_raw = r_d[W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q      <= '0;
      a_q      <= '0;
      d_q      <= '0;
      count_q  <= '0;
      active_q <= 1'b0;
    end else begin
      r_q      <= r_d;
      a_q      <= a_d;
      d_q      <= d_d;
      count_q  <= count_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle divider with start/done handshake: sign pre/post-processing and
// divide-by-zero override around the unsigned engine in seq_div_core.
//
// state | meaning
// IDLE  | waiting for start, last results held
// CALC  | core iterating, one quotient bit per cycle
// DONE  | done pulse cycle, a new start is accepted here
module seq_divider #(
  parameter int W      = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         in_ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);
  import div_pkg::*;

  localparam bit W_OK = w_in_range(W);

  if (!W_OK) begin : g_bad_width
    $error("seq_divider: W must be within 2..32");
  end

  div_state_e state_q, state_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         dbz_q, dbz_d;
  logic [W-1:0] quotient_q, quotient_d;
  logic [W-1:0] remainder_q, remainder_d;
  logic [W-1:0] dvd_orig_q, dvd_orig_d;
  logic         neg_quo_q, neg_quo_d;
  logic         neg_rem_q, neg_rem_d;
  logic         zero_q, zero_d;

  logic             accept;
  logic             step_done;
  logic [W_MAX-1:0] dvd_ext, dvs_ext;
  logic [W-1:0]     dvd_mag, dvs_mag;
  logic [W-1:0]     q_raw, r_raw;

  assign in_ready = (state_q != CALC);
  assign accept   = start && in_ready;

  always_comb begin
    dvd_ext = SIGNED ? W_MAX'(signed'(dividend)) : W_MAX'(dividend);
    dvs_ext = SIGNED ? W_MAX'(signed'(divisor))  : W_MAX'(divisor);
    dvd_mag = W'(abs_w(dvd_ext, SIGNED));
    dvs_mag = W'(abs_w(dvs_ext, SIGNED));
  end

  seq_div_core #(.W(W)) u_core (
    .clk          (clk),
    .reset        (reset),
    .load         (accept),
    .dividend_mag (dvd_mag),
    .divisor_mag  (dvs_mag),
    .step_done    (step_done),
    .q_raw        (q_raw),
    .r_raw        (r_raw)
  );

  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dvd_orig_d  = dvd_orig_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    zero_d      = zero_q;

    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (step_done) state_d = DONE;
      DONE:    state_d = accept ? CALC : IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC);

    if (accept) begin
      dvd_orig_d = dividend;
      zero_d     = (divisor == '0);
      neg_quo_d  = SIGNED && (dividend[W-1] ^ divisor[W-1]);
      neg_rem_d  = SIGNED && dividend[W-1];
    end

    // The engine still runs on a zero divisor so latency never changes;
    // its raw result is simply discarded here.
    if (step_done) begin
      done_d = 1'b1;
      if (zero_q) begin
        quotient_d  = (SIGNED && neg_rem_q) ? W'(1) : '1;
        remainder_d = dvd_orig_q;
        dbz_d       = 1'b1;
      end else begin
        quotient_d  = W'(neg_w(W_MAX'(q_raw), neg_quo_q));
        remainder_d = W'(neg_w(W_MAX'(r_raw), neg_rem_q));
        dbz_d       = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dvd_orig_q  <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dvd_orig_q  <= dvd_orig_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      zero_q      <= zero_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: six instances (W=16/8/32, unsigned and signed)
// checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_seq_divider;

  localparam int NI = 6;  // 0:u16 1:s16 2:u8 3:s8 4:u32 5:s32

  logic          clk = 1'b0;
  logic          reset;
  logic [NI-1:0] st;
  logic [31:0]   dvd, dvs;
  wire  [NI-1:0] done_o, busy_o, rdy_o, dbz_o;
  wire  [31:0]   q_o [NI];
  wire  [31:0]   r_o [NI];

  int n_checks = 0;
  int n_fail   = 0;
  int lat  [NI];
  int bcnt [NI];
  int dcnt [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int GW = (g < 2) ? 16 : (g < 4) ? 8 : 32;
    localparam bit GS = ((g % 2) == 1);
    logic [GW-1:0] q, r;
    seq_divider #(.W(GW), .SIGNED(GS)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .start       (st[g]),
      .dividend    (dvd[GW-1:0]),
      .divisor     (dvs[GW-1:0]),
      .in_ready    (rdy_o[g]),
      .busy        (busy_o[g]),
      .done        (done_o[g]),
      .quotient    (q),
      .remainder   (r),
      .div_by_zero (dbz_o[g])
    );
    assign q_o[g] = 32'(q);
    assign r_o[g] = 32'(r);
  end

  function automatic bit s_of(input int g);
    return (g % 2) == 1;
  endfunction

  function automatic longint sx(input int w, input bit s, input logic [31:0] v);
    logic [63:0] u;
    u = {32'd0, v} & ((64'd1 << w) - 64'd1);
    if (s && u[w-1]) return longint'(u) - longint'(64'd1 << w);
    return longint'(u);
  endfunction

  // Reference: plain integer division on mathematical values, then wrapped.
  function automatic void model(input int w, input bit s, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] q,
                                output logic [31:0] r, output logic z);
    longint sa, sb;
    logic [63:0] mk;
    mk = (64'd1 << w) - 64'd1;
    sa = sx(w, s, a);
    sb = sx(w, s, b);
    z  = (sb == 0);
    if (z) begin
      q = (s && sa < 0) ? 32'd1 : mk[31:0];
      r = 32'(64'(sa) & mk);
    end else begin
      q = 32'(64'(sa / sb) & mk);
      r = 32'(64'(sa % sb) & mk);
    end
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [63:0] mk;
    int sel;
    mk  = (64'd1 << w) - 64'd1;
    sel = int'($urandom_range(0, 7));
    case (sel)
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'(mk >> 1);
      3:       return 32'(64'd1 << (w - 1));
      4:       return mk[31:0];
      default: return 32'(64'($urandom) & mk);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [NI-1:0] m, input logic [31:0] a, input logic [31:0] b);
    dvd = a; dvs = b; st = m;
    tick();
    st = '0; dvd = ~a; dvs = ~b;
    for (int g = 0; g < NI; g++) begin lat[g] = -1; bcnt[g] = 0; dcnt[g] = 0; end
    for (int c = 0; c <= 40; c++) begin
      for (int g = 0; g < NI; g++) begin
        if (busy_o[g]) bcnt[g]++;
        if (done_o[g]) begin
          dcnt[g]++;
          if (lat[g] < 0) lat[g] = c;
        end
      end
      if (c < 40) tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; st = '0; dvd = '0; dvs = '0;
    repeat (3) tick();
    reset = 1'b0;
    for (int g = 0; g < NI; g++) begin
      n_checks++;
      if ({rdy_o[g], busy_o[g], done_o[g], dbz_o[g]} !== 4'b1000) begin
        n_fail++;
        $display("FAIL reset_ctl g=%0d: got %b expected 1000", g,
                 {rdy_o[g], busy_o[g], done_o[g], dbz_o[g]});
      end
      n_checks++;
      if ({q_o[g], r_o[g]} !== 64'd0) begin
        n_fail++;
        $display("FAIL reset_res g=%0d: got q=%h r=%h expected 0", g, q_o[g], r_o[g]);
      end
    end
  endtask

  task automatic test_unsigned();
    run(6'b000001, 32'd100, 32'd7);
    n_checks++;
    if (lat[0] !== 16) begin n_fail++; $display("FAIL u_latency: got %0d expected 16", lat[0]); end
    n_checks++;
    if (bcnt[0] !== 16) begin n_fail++; $display("FAIL u_busy_cycles: got %0d expected 16", bcnt[0]); end
    n_checks++;
    if (dcnt[0] !== 1) begin n_fail++; $display("FAIL u_done_pulses: got %0d expected 1", dcnt[0]); end
    n_checks++;
    if ({q_o[0], r_o[0], dbz_o[0]} !== {32'd14, 32'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL u_100_7: got q=%0d r=%0d z=%b expected q=14 r=2 z=0", q_o[0], r_o[0], dbz_o[0]);
    end
    repeat (5) tick();
    n_checks++;
    if ({q_o[0], r_o[0], done_o[0]} !== {32'd14, 32'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL u_hold: got q=%0d r=%0d done=%b expected 14 2 0", q_o[0], r_o[0], done_o[0]);
    end
  endtask

  task automatic test_div_zero();
    run(6'b000001, 32'h1234, 32'd0);
    n_checks++;
    if ({q_o[0], r_o[0], dbz_o[0]} !== {32'hFFFF, 32'h1234, 1'b1} || lat[0] !== 16) begin
      n_fail++;
      $display("FAIL dbz_u16: got q=%h r=%h z=%b lat=%0d expected ffff 1234 1 16",
               q_o[0], r_o[0], dbz_o[0], lat[0]);
    end
    run(6'b000010, 32'h8765, 32'd0);
    n_checks++;
    if ({q_o[1], r_o[1], dbz_o[1]} !== {32'h0001, 32'h8765, 1'b1}) begin
      n_fail++;
      $display("FAIL dbz_s16_neg: got q=%h r=%h z=%b expected 0001 8765 1", q_o[1], r_o[1], dbz_o[1]);
    end
    run(6'b000010, 32'h0005, 32'd0);
    n_checks++;
    if ({q_o[1], r_o[1], dbz_o[1]} !== {32'hFFFF, 32'h0005, 1'b1}) begin
      n_fail++;
      $display("FAIL dbz_s16_pos: got q=%h r=%h z=%b expected ffff 0005 1", q_o[1], r_o[1], dbz_o[1]);
    end
  endtask

  task automatic test_signed();
    logic [31:0] tv [4][4];
    tv[0] = '{32'hFFF9, 32'h0002, 32'hFFFD, 32'hFFFF};
    tv[1] = '{32'h0007, 32'hFFFE, 32'hFFFD, 32'h0001};
    tv[2] = '{32'h8000, 32'hFFFF, 32'h8000, 32'h0000};
    tv[3] = '{32'hFFF9, 32'hFFFE, 32'h0003, 32'hFFFF};
    for (int i = 0; i < 4; i++) begin
      run(6'b000010, tv[i][0], tv[i][1]);
      n_checks++;
      if ({q_o[1], r_o[1], dbz_o[1]} !== {tv[i][2], tv[i][3], 1'b0} || lat[1] !== 16) begin
        n_fail++;
        $display("FAIL signed_%0d: got q=%h r=%h z=%b lat=%0d expected q=%h r=%h z=0 lat=16",
                 i, q_o[1], r_o[1], dbz_o[1], lat[1], tv[i][2], tv[i][3]);
      end
    end
  endtask

  task automatic test_busy_start();
    int nd, lt;
    nd = 0; lt = -1;
    dvd = 32'd100; dvs = 32'd7; st = 6'b000001;
    tick();
    st = '0;
    for (int c = 0; c <= 40; c++) begin
      if (done_o[0]) begin nd++; if (lt < 0) lt = c; end
      if (c == 5) begin st = 6'b000001; dvd = 32'd50; dvs = 32'd3; end
      else st = '0;
      if (c < 40) tick();
    end
    n_checks++;
    if ({q_o[0], r_o[0]} !== {32'd14, 32'd2} || nd !== 1 || lt !== 16) begin
      n_fail++;
      $display("FAIL busy_start: got q=%0d r=%0d dones=%0d lat=%0d expected 14 2 1 16",
               q_o[0], r_o[0], nd, lt);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    dvd = 32'd1000; dvs = 32'd10; st = 6'b000001;
    tick();
    st = '0;
    c = 0;
    while (!done_o[0] && c < 40) begin tick(); c++; end
    n_checks++;
    if (c !== 16 || {q_o[0], r_o[0]} !== {32'd100, 32'd0}) begin
      n_fail++;
      $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d expected 16 100 0", c, q_o[0], r_o[0]);
    end
    dvd = 32'd999; dvs = 32'd4; st = 6'b000001;
    tick();
    st = '0;
    n_checks++;
    if (done_o[0] !== 1'b0 || busy_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: got done=%b busy=%b expected 0 1", done_o[0], busy_o[0]);
    end
    c = 1;
    while (!done_o[0] && c < 40) begin tick(); c++; end
    n_checks++;
    if (c !== 17 || {q_o[0], r_o[0]} !== {32'd249, 32'd3}) begin
      n_fail++;
      $display("FAIL b2b_second: got gap=%0d q=%0d r=%0d expected 17 249 3", c, q_o[0], r_o[0]);
    end
  endtask

  task automatic test_reset_mid();
    int nd;
    dvd = 32'd500; dvs = 32'd3; st = 6'b000001;
    tick();
    st = '0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({rdy_o[0], busy_o[0], done_o[0], dbz_o[0]} !== 4'b1000 || {q_o[0], r_o[0]} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got ctl=%b q=%h r=%h expected 1000 0 0",
               {rdy_o[0], busy_o[0], done_o[0], dbz_o[0]}, q_o[0], r_o[0]);
    end
    nd = 0;
    repeat (25) begin tick(); if (done_o[0]) nd++; end
    n_checks++;
    if (nd !== 0) begin n_fail++; $display("FAIL reset_no_done: got %0d pulses expected 0", nd); end
    dvd = 32'd9; dvs = 32'd2; st = 6'b000001; reset = 1'b1;
    tick();
    reset = 1'b0; st = '0;
    nd = 0;
    repeat (20) begin if (busy_o[0] || done_o[0]) nd++; tick(); end
    n_checks++;
    if (nd !== 0) begin n_fail++; $display("FAIL reset_wins: got %0d active cycles expected 0", nd); end
    run(6'b000001, 32'd255, 32'd16);
    n_checks++;
    if ({q_o[0], r_o[0]} !== {32'd15, 32'd15} || lat[0] !== 16) begin
      n_fail++;
      $display("FAIL after_reset: got q=%0d r=%0d lat=%0d expected 15 15 16", q_o[0], r_o[0], lat[0]);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, eq, er;
    logic ez;
    logic [NI-1:0] m;
    int w;
    bit s;
    longint sq, sr, sb, sa, mk;
    for (int grp = 0; grp < 3; grp++) begin
      w = (grp == 0) ? 8 : (grp == 1) ? 16 : 32;
      m = (grp == 0) ? 6'b001100 : (grp == 1) ? 6'b000011 : 6'b110000;
      mk = longint'((64'd1 << w) - 64'd1);
      for (int it = 0; it < 50; it++) begin
        a = pick(w);
        b = pick(w);
        run(m, a, b);
        for (int g = 0; g < NI; g++) begin
          if (m[g]) begin
            s = s_of(g);
            model(w, s, a, b, eq, er, ez);
            n_checks++;
            if (lat[g] !== w || dcnt[g] !== 1) begin
              n_fail++;
              $display("FAIL rnd_timing g=%0d: got lat=%0d dones=%0d expected %0d 1", g, lat[g], dcnt[g], w);
            end
            n_checks++;
            if ({q_o[g], r_o[g], dbz_o[g]} !== {eq, er, ez}) begin
              n_fail++;
              $display("FAIL rnd_result g=%0d a=%h b=%h: got q=%h r=%h z=%b expected q=%h r=%h z=%b",
                       g, a, b, q_o[g], r_o[g], dbz_o[g], eq, er, ez);
            end
            if (!ez) begin
              sq = sx(w, s, q_o[g]);
              sr = sx(w, s, r_o[g]);
              sb = sx(w, s, b);
              sa = sx(w, s, a);
              n_checks++;
              if (((sq * sb + sr) & mk) !== (sa & mk)) begin
                n_fail++;
                $display("FAIL rnd_identity g=%0d: got q*d+r=%0d expected %0d", g, (sq * sb + sr) & mk, sa & mk);
              end
              n_checks++;
              if (((sr < 0) ? -sr : sr) >= ((sb < 0) ? -sb : sb)) begin
                n_fail++;
                $display("FAIL rnd_rem_bound g=%0d: got |r|=%0d expected below |d|=%0d", g,
                         (sr < 0) ? -sr : sr, (sb < 0) ? -sb : sb);
              end
            end
          end
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_unsigned();
    test_div_zero();
    test_signed();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
